// File: rtl/fm_interp_pkg.sv
// -----------------------------------------------------------------------------
// fm_interp_pkg
// Shared types and constants for the FM linear-interpolating upsampler.
//
// Contents:
//   state_t        ramp controller states (EMPTY, RAMP, HOLD)
//   N, ACC_W       upsample factor and accumulator width for the default build
//   sample_t       signed audio sample at the default width
//   acc_t          signed accumulator (value x N plus one guard bit)
//   tick_cnt_width helper sizing a 0..div-1 counter
// -----------------------------------------------------------------------------
package fm_interp_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_RATIO_LOG2 = 3;
    localparam int DEF_TICK_DIV   = 94;

    localparam int N     = 1 << DEF_RATIO_LOG2;
    localparam int ACC_W = DEF_DATA_WIDTH + DEF_RATIO_LOG2 + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]          acc_t;

    // A divider of 1 still needs a one-bit counter to keep the logic legal.
    function automatic int tick_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/fm_tick_gen.sv
// -----------------------------------------------------------------------------
// fm_tick_gen
// Free-running 0..TICK_DIV-1 counter that marks the last count with a tick.
// Used to derive sample-rate strobes from the 27 MHz system clock.
//
// Ports:
//   clk_27m  in   system clock
//   reset    in   asynchronous, active-high reset (counter returns to 0)
//   tick     out  high for the one cycle in which the counter is TICK_DIV-1
// -----------------------------------------------------------------------------
module fm_tick_gen
    import fm_interp_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk_27m,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = tick_cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Wrap on the last count so the period is exactly TICK_DIV cycles.
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fm_interp.sv
// -----------------------------------------------------------------------------
// fm_interp
// Linear-interpolating upsampler. Each accepted input sample starts a ramp
// from the current output to the new sample, taken in 2^RATIO_LOG2 equal
// steps, one step per output tick (every TICK_DIV clocks).
//
// The accumulator holds value x N, so adding the raw difference N times lands
// exactly on target x N and the ramp endpoint carries no rounding error.
//
// Build option:
//   FM_INTERP_ROUND_EN  defined   -> outputs rounded half up
//                       undefined -> outputs truncated (arithmetic floor)
//
// Ports:
//   clk_27m     in   system clock
//   reset       in   asynchronous, active-high reset
//   data_in     in   signed input sample, taken when data_valid = 1
//   data_valid  in   one-cycle strobe marking a new input sample
//   data_out    out  signed interpolated sample, registered
//   out_strobe  out  one-cycle pulse per output sample period
//   underrun    out  one-cycle pulse when a tick finds the ramp already done
// -----------------------------------------------------------------------------
module fm_interp
    import fm_interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RATIO_LOG2 = DEF_RATIO_LOG2,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic                         clk_27m,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_strobe,
    output logic                         underrun
);

    localparam int                    AW         = DATA_WIDTH + RATIO_LOG2 + 1;
    localparam logic [RATIO_LOG2-1:0] PHASE_LAST = '1;

    state_t                       state;
    state_t                       state_next;
    logic [RATIO_LOG2-1:0]        phase;
    logic [RATIO_LOG2-1:0]        phase_next;
    logic                         do_load;
    logic                         do_step;
    logic                         underrun_next;
    logic                         tick;

    logic signed [AW-1:0]         acc;
    logic signed [AW-1:0]         acc_next;
    logic signed [AW-1:0]         acc_load;
    logic signed [DATA_WIDTH:0]   delta;
    logic signed [DATA_WIDTH:0]   delta_load;
    logic signed [DATA_WIDTH-1:0] step_out;

    fm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_27m (clk_27m),
        .reset   (reset),
        .tick    (tick)
    );

    // A load restarts from whatever is on the output right now, so a ramp
    // interrupted mid-way continues without a step.
    assign acc_load   = {data_out[DATA_WIDTH-1], data_out, {RATIO_LOG2{1'b0}}};
    assign delta_load = (DATA_WIDTH+1)'(data_in) - (DATA_WIDTH+1)'(data_out);
    assign acc_next   = acc + AW'(delta);

`ifdef FM_INTERP_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1 << (RATIO_LOG2 - 1));
    assign step_out = DATA_WIDTH'((acc_next + HALF) >>> RATIO_LOG2);
`else
    assign step_out = DATA_WIDTH'(acc_next >>> RATIO_LOG2);
`endif

    // State register.
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. A new sample always wins over a tick in
    // the same cycle; that tick then produces a strobe with no output change.
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        do_load       = 1'b0;
        do_step       = 1'b0;
        underrun_next = 1'b0;

        if (data_valid) begin
            state_next = RAMP;
            phase_next = '0;
            do_load    = 1'b1;
        end else if (tick) begin
            case (state)
                RAMP: begin
                    do_step = 1'b1;
                    if (phase == PHASE_LAST) begin
                        state_next = HOLD;
                        phase_next = '0;
                    end else begin
                        phase_next = phase + RATIO_LOG2'(1);
                    end
                end
                HOLD: begin
                    underrun_next = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: strobes follow the tick by one cycle, aligned with data_out.
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            acc        <= '0;
            delta      <= '0;
            data_out   <= '0;
            out_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            phase      <= phase_next;
            out_strobe <= tick;
            underrun   <= underrun_next;
            if (do_load) begin
                acc   <= acc_load;
                delta <= delta_load;
            end else if (do_step) begin
                acc      <= acc_next;
                data_out <= step_out;
            end
        end
    end

endmodule

// File: tb/tb_fm_interp.sv
// -----------------------------------------------------------------------------
// tb_fm_interp
// Directed bench for fm_interp with DATA_WIDTH=16, RATIO_LOG2=3, TICK_DIV=4.
// Expected ramp values are written out by hand; the small-step ramp has one
// table per rounding build (FM_INTERP_ROUND_EN).
// -----------------------------------------------------------------------------
module tb_fm_interp;

    localparam int DW = 16;

    logic                 clk_27m;
    logic                 reset;
    logic signed [DW-1:0] data_in;
    logic                 data_valid;
    logic signed [DW-1:0] data_out;
    logic                 out_strobe;
    logic                 underrun;

    int checks;
    int failures;

    fm_interp #(
        .DATA_WIDTH (16),
        .RATIO_LOG2 (3),
        .TICK_DIV   (4)
    ) dut (
        .clk_27m    (clk_27m),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .out_strobe (out_strobe),
        .underrun   (underrun)
    );

    // 10 ns clock.
    initial clk_27m = 1'b0;
    always #5 clk_27m = ~clk_27m;

    // Backstop in case something upstream stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One-cycle data_valid pulse, driven between clock edges.
    task automatic applyStimulus(input int value);
        @(negedge clk_27m);
        data_in    = DW'(value);
        data_valid = 1'b1;
        @(negedge clk_27m);
        data_valid = 1'b0;
    endtask

    // Advance to the next edge that leaves out_strobe high, within a bound.
    task automatic waitStrobe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk_27m);
            #1;
            if (out_strobe) seen = 1'b1;
        end
        if (!seen) checkOutput({tag, "_strobe_timeout"}, 0, 1);
    endtask

    // Check the next n strobed outputs against a table; no underrun allowed.
    task automatic checkRamp(input string tag, input int n, input int exp_vals[8]);
        int ur_count;
        ur_count = 0;
        for (int k = 0; k < n; k++) begin
            waitStrobe(tag);
            checkOutput($sformatf("%s_%0d", tag, k), int'(data_out), exp_vals[k]);
            if (underrun) ur_count++;
        end
        checkOutput({tag, "_underrun"}, ur_count, 0);
    endtask

    initial begin
        int exp_vals[8];
        int strobes;
        int unders;
        int nonzero;

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;

        // Reset state.
        #22;
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_out_strobe", int'(out_strobe), 0);
        checkOutput("reset_underrun", int'(underrun), 0);
        @(negedge clk_27m);
        reset = 1'b0;

        // Idle in EMPTY: strobe every 4 cycles, never an underrun.
        strobes = 0; unders = 0; nonzero = 0;
        repeat (20) begin
            @(posedge clk_27m);
            #1;
            if (out_strobe) strobes++;
            if (underrun) unders++;
            if (data_out != 0) nonzero++;
        end
        checkOutput("idle_strobes", strobes, 5);
        checkOutput("idle_underruns", unders, 0);
        checkOutput("idle_nonzero", nonzero, 0);

        // 0 -> 800 in steps of 100.
        applyStimulus(800);
        exp_vals = '{100, 200, 300, 400, 500, 600, 700, 800};
        checkRamp("up800", 8, exp_vals);

        // One tick past the end: held value plus underrun.
        waitStrobe("hold");
        checkOutput("hold_data_out", int'(data_out), 800);
        checkOutput("hold_underrun", int'(underrun), 1);

        // Load -800 exactly on a tick edge: that strobe keeps 800.
        repeat (3) @(posedge clk_27m);
        @(negedge clk_27m);
        data_in    = -16'sd800;
        data_valid = 1'b1;
        @(posedge clk_27m);
        #1;
        checkOutput("coinc_strobe", int'(out_strobe), 1);
        checkOutput("coinc_data_out", int'(data_out), 800);
        checkOutput("coinc_underrun", int'(underrun), 0);
        @(negedge clk_27m);
        data_valid = 1'b0;
        exp_vals = '{600, 400, 200, 0, -200, -400, -600, -800};
        checkRamp("down800", 8, exp_vals);

        // Back to 0.
        applyStimulus(0);
        repeat (8) waitStrobe("to_zero");
        checkOutput("to_zero_end", int'(data_out), 0);

        // 0 -> 800 interrupted at 400, restart towards 0.
        applyStimulus(800);
        exp_vals = '{100, 200, 300, 400, 0, 0, 0, 0};
        checkRamp("part800", 4, exp_vals);
        applyStimulus(0);
        exp_vals = '{350, 300, 250, 200, 150, 100, 50, 0};
        checkRamp("restart0", 8, exp_vals);

        // Small step exposes the output quantisation.
        applyStimulus(3);
`ifdef FM_INTERP_ROUND_EN
        exp_vals = '{0, 1, 1, 2, 2, 2, 3, 3};
`else
        exp_vals = '{0, 0, 1, 1, 1, 2, 2, 3};
`endif
        checkRamp("small3", 8, exp_vals);

        // Asynchronous reset in the middle of a ramp.
        applyStimulus(800);
        waitStrobe("pre_reset");
        waitStrobe("pre_reset");
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset_data_out", int'(data_out), 0);
        checkOutput("midreset_out_strobe", int'(out_strobe), 0);
        checkOutput("midreset_underrun", int'(underrun), 0);
        @(negedge clk_27m);
        reset = 1'b0;
        strobes = 0; unders = 0; nonzero = 0;
        repeat (12) begin
            @(posedge clk_27m);
            #1;
            if (out_strobe) strobes++;
            if (underrun) unders++;
            if (data_out != 0) nonzero++;
        end
        checkOutput("post_reset_strobes", strobes, 3);
        checkOutput("post_reset_underruns", unders, 0);
        checkOutput("post_reset_nonzero", nonzero, 0);

        // Back-to-back loads: the second (1600) wins, ramp starts from 0.
        @(negedge clk_27m);
        data_in    = 16'sd800;
        data_valid = 1'b1;
        @(negedge clk_27m);
        data_in    = 16'sd1600;
        @(negedge clk_27m);
        data_valid = 1'b0;
        exp_vals = '{200, 400, 600, 800, 1000, 1200, 1400, 1600};
        checkRamp("double", 8, exp_vals);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
